// File: rtl/nubus_slave_resp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nubus_pkg
//  Description : Shared constants, state encoding and transfer-mode decode
//                for the NuBus slave responder.
//                - TM_* : {tm1n,tm0n} status codes driven during ACK
//                - WRITE_WR_* : local byte-strobe patterns
//                - state_t : responder FSM states
//                - mode_to_wstrb : transfer mode + low address -> strobes
//  Revision    : 1.0 - initial release
// ============================================================================
package nubus_pkg;

    localparam logic [1:0] TM_COMPLETE = 2'b11;
    localparam logic [1:0] TM_ERROR    = 2'b10;
    localparam logic [1:0] TM_TIMEOUT  = 2'b01;
    localparam logic [1:0] TM_TRYAGAIN = 2'b00;

    localparam logic [3:0] WRITE_WR_WORD   = 4'b1111;
    localparam logic [3:0] WRITE_WR_HALF_0 = 4'b0011;
    localparam logic [3:0] WRITE_WR_HALF_1 = 4'b1100;
    localparam logic [3:0] WRITE_WR_BYTE_0 = 4'b0001;
    localparam logic [3:0] WRITE_WR_BYTE_1 = 4'b0010;
    localparam logic [3:0] WRITE_WR_BYTE_2 = 4'b0100;
    localparam logic [3:0] WRITE_WR_BYTE_3 = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_MEM   = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    // tm0n and adn are bus-polarity (active low); the lane bits are
    // inverted here so callers can pass the sampled bus directly.
    function automatic logic [3:0] mode_to_wstrb(input logic tm0n, input logic [1:0] adn);
        logic [1:0] lane;
        logic [3:0] strb;
        lane = ~adn;
        if (!tm0n) begin
            case (lane)
                2'b00:   strb = WRITE_WR_BYTE_0;
                2'b01:   strb = WRITE_WR_BYTE_1;
                2'b10:   strb = WRITE_WR_BYTE_2;
                default: strb = WRITE_WR_BYTE_3;
            endcase
        end else begin
            case (lane)
                2'b00:   strb = WRITE_WR_HALF_0;
                2'b10:   strb = WRITE_WR_HALF_1;
                default: strb = WRITE_WR_WORD;   // 2'b11 word, 2'b01 reserved -> word
            endcase
        end
        return strb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nubus_slave_resp_if.sv
`default_nettype none
// ============================================================================
//  Module      : nubus_slave_resp_if
//  Description : NuBus slave-side bus signals plus the local memory request
//                channel. The slave modport is the responder's view; the
//                master modport is the view of the bus/card environment.
//                nub_* inputs are sampled bus levels (active low);
//                nub_*_o / *_oe are the responder's drive values/enables;
//                mem_* carry one true-polarity local transaction.
//  Revision    : 1.0 - initial release
// ============================================================================
interface nubus_slave_resp_if;

    logic [3:0]  nub_idn;
    logic        nub_startn;
    logic [31:0] nub_adn;
    logic        nub_tm0n;
    logic        nub_tm1n;
    logic [31:0] nub_adn_o;
    logic        nub_adn_oe;
    logic [1:0]  nub_tmn_o;
    logic        nub_ackn_o;
    logic        nub_ctl_oe;

    logic        mem_valid;
    logic [3:0]  mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_myslot;
    logic        mem_myexp;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport slave (
        input  nub_idn, nub_startn, nub_adn, nub_tm0n, nub_tm1n,
        output nub_adn_o, nub_adn_oe, nub_tmn_o, nub_ackn_o, nub_ctl_oe,
        output mem_valid, mem_write, mem_addr, mem_wdata, mem_myslot, mem_myexp,
        input  mem_ready, mem_rdata
    );

    modport master (
        output nub_idn, nub_startn, nub_adn, nub_tm0n, nub_tm1n,
        input  nub_adn_o, nub_adn_oe, nub_tmn_o, nub_ackn_o, nub_ctl_oe,
        input  mem_valid, mem_write, mem_addr, mem_wdata, mem_myslot, mem_myexp,
        output mem_ready, mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/nubus_slave_resp_decode.sv
`default_nettype none
// ============================================================================
//  Module      : nubus_slave_decode
//  Description : Combinational address/mode decode for the NuBus responder.
//  Ports       : adn      in  32  sampled address bus (active low)
//                idn      in  4   slot ID (active low)
//                tm0n     in  1   transfer mode bit 0 (active low)
//                addr     out 32  true-polarity address
//                slot_hit out 1   address in this card's $Fsxx_xxxx space
//                exp_hit  out 1   address in this card's $sxxx_xxxx space
//                strobe   out 4   byte strobes for the access
//  Revision    : 1.0 - initial release
// ============================================================================
module nubus_slave_decode
    import nubus_pkg::*;
#(
    parameter bit SLOT_ENABLE = 1'b1,
    parameter bit EXP_ENABLE  = 1'b1
) (
    input  logic [31:0] adn,
    input  logic [3:0]  idn,
    input  logic        tm0n,
    output logic [31:0] addr,
    output logic        slot_hit,
    output logic        exp_hit,
    output logic [3:0]  strobe
);

    logic [3:0] slot_id;

    assign slot_id  = ~idn;
    assign addr     = ~adn;
    assign slot_hit = SLOT_ENABLE && (addr[31:24] == {4'hF, slot_id});
    // Super slot $F is the standard slot space, so it never counts as expansion.
    assign exp_hit  = EXP_ENABLE && (addr[31:28] == slot_id) && (addr[31:28] != 4'hF);
    assign strobe   = mode_to_wstrb(tm0n, adn[1:0]);

endmodule
`default_nettype wire

// File: rtl/nubus_slave_resp.sv
`default_nettype none
// ============================================================================
//  Module      : nubus_slave_resp
//  Description : NuBus slave responder. Detects START cycles addressed to
//                this card, runs one local mem_* transaction and terminates
//                the bus cycle with ACK, status and (for reads) data.
//  Ports       : nub_clkn   in  NuBus clock; FSM/mem_* on falling edge,
//                                bus drive registers on rising edge
//                nub_resetn in  asynchronous active-low reset
//                bus        slave modport of nubus_slave_resp_if
//  Revision    : 1.0 - initial release
// ============================================================================
module nubus_slave_resp
    import nubus_pkg::*;
#(
    parameter bit SLOT_ENABLE    = 1'b1,
    parameter bit EXP_ENABLE     = 1'b1,
    parameter int TIMEOUT_CLOCKS = 255
) (
    input  logic              nub_clkn,
    input  logic              nub_resetn,
    nubus_slave_resp_if.slave bus
);

    // The wait counter is compared against the last count before the
    // timeout fires, so mem_valid stays up for exactly TIMEOUT_CLOCKS clocks.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CLOCKS - 1);

    logic [31:0] dec_addr;
    logic        slot_hit;
    logic        exp_hit;
    logic [3:0]  dec_strobe;

    state_t      state;
    logic        is_write;
    logic [3:0]  wstrb;
    logic [7:0]  wait_cnt;
    logic [1:0]  status;
    logic [31:0] rdata;

    nubus_slave_decode #(
        .SLOT_ENABLE (SLOT_ENABLE),
        .EXP_ENABLE  (EXP_ENABLE)
    ) u_decode (
        .adn      (bus.nub_adn),
        .idn      (bus.nub_idn),
        .tm0n     (bus.nub_tm0n),
        .addr     (dec_addr),
        .slot_hit (slot_hit),
        .exp_hit  (exp_hit),
        .strobe   (dec_strobe)
    );

    // Sampling side: FSM and local request registers.
    always_ff @(negedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            state          <= ST_IDLE;
            is_write       <= 1'b0;
            wstrb          <= 4'b0000;
            wait_cnt       <= 8'd0;
            status         <= TM_COMPLETE;
            rdata          <= 32'h0;
            bus.mem_valid  <= 1'b0;
            bus.mem_write  <= 4'b0000;
            bus.mem_addr   <= 32'h0;
            bus.mem_wdata  <= 32'h0;
            bus.mem_myslot <= 1'b0;
            bus.mem_myexp  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!bus.nub_startn && (slot_hit || exp_hit)) begin
                        bus.mem_addr   <= dec_addr & 32'hFFFF_FFFC;
                        bus.mem_myslot <= slot_hit;
                        bus.mem_myexp  <= exp_hit;
                        is_write       <= !bus.nub_tm1n;
                        wstrb          <= dec_strobe;
                        wait_cnt       <= 8'd0;
                        if (!bus.nub_tm1n) begin
                            state <= ST_WDATA;
                        end else begin
                            bus.mem_valid <= 1'b1;
                            bus.mem_write <= 4'b0000;
                            state         <= ST_MEM;
                        end
                    end
                end
                ST_WDATA: begin
                    bus.mem_wdata <= ~bus.nub_adn;
                    bus.mem_write <= wstrb;
                    bus.mem_valid <= 1'b1;
                    state         <= ST_MEM;
                end
                ST_MEM: begin
                    if (bus.mem_ready) begin
                        rdata         <= bus.mem_rdata;
                        status        <= TM_COMPLETE;
                        bus.mem_valid <= 1'b0;
                        bus.mem_write <= 4'b0000;
                        state         <= ST_ACK;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        rdata         <= 32'hFFFF_FFFF;
                        status        <= TM_ERROR;
                        bus.mem_valid <= 1'b0;
                        bus.mem_write <= 4'b0000;
                        state         <= ST_ACK;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_ACK: begin
                    // ACK is already on the bus from the preceding rising edge.
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Driving side: ACK/status/data registers, held exactly while in ST_ACK.
    always_ff @(posedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            bus.nub_ackn_o <= 1'b1;
            bus.nub_tmn_o  <= 2'b11;
            bus.nub_ctl_oe <= 1'b0;
            bus.nub_adn_o  <= 32'hFFFF_FFFF;
            bus.nub_adn_oe <= 1'b0;
        end else if (state == ST_ACK) begin
            bus.nub_ackn_o <= 1'b0;
            bus.nub_tmn_o  <= status;
            bus.nub_ctl_oe <= 1'b1;
            bus.nub_adn_o  <= is_write ? 32'hFFFF_FFFF : ~rdata;
            bus.nub_adn_oe <= !is_write;
        end else begin
            bus.nub_ackn_o <= 1'b1;
            bus.nub_tmn_o  <= 2'b11;
            bus.nub_ctl_oe <= 1'b0;
            bus.nub_adn_o  <= 32'hFFFF_FFFF;
            bus.nub_adn_oe <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nubus_slave_resp.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_nubus_slave_resp
//  Description : Scoreboard bench for nubus_slave_resp. Stimulus pushes the
//                expected local request and expected ACK into queues; a
//                behavioural memory pops/compares requests and a negedge
//                monitor pops/compares ACKs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nubus_slave_resp;

    localparam int TOUT = 8;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] wdata;
        logic        myslot;
        int          wait_clks;
        int          vlen;      // expected mem_valid length in clocks, 0 = unchecked
    } mem_exp_t;

    typedef struct {
        logic [1:0]  tmn;
        logic        oe;
        logic [31:0] adn_o;
        int          at_cyc;
    } ack_exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    mem_exp_t mem_q[$];
    ack_exp_t ack_q[$];
    logic [31:0] mem [logic [31:0]];

    nubus_slave_resp_if bus();

    nubus_slave_resp #(
        .SLOT_ENABLE    (1'b1),
        .EXP_ENABLE     (1'b1),
        .TIMEOUT_CLOCKS (TOUT)
    ) dut (
        .nub_clkn   (clk),
        .nub_resetn (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got 1 occurrence, expected 0", name);
    endtask

    // ---------------- behavioural local memory + request checker ----------
    mem_exp_t    m_cur;
    logic        m_busy = 1'b0;
    int          m_cnt  = 0;
    int          m_len  = 0;
    logic [31:0] m_old;

    always @(posedge clk) begin
        if (bus.mem_valid) begin
            if (!m_busy) begin
                m_busy = 1'b1;
                m_cnt  = 0;
                m_len  = 0;
                if (mem_q.size() == 0) begin
                    unexpected("unexpected_mem_req");
                    m_cur.wait_clks = 1000;
                    m_cur.vlen      = 0;
                end else begin
                    m_cur = mem_q.pop_front();
                    chk("mem_addr",   bus.mem_addr,   m_cur.addr);
                    chk("mem_write",  {28'h0, bus.mem_write}, {28'h0, m_cur.strobe});
                    if (m_cur.strobe != 4'b0000)
                        chk("mem_wdata", bus.mem_wdata, m_cur.wdata);
                    chk("mem_myslot", {31'h0, bus.mem_myslot}, {31'h0, m_cur.myslot});
                    chk("mem_myexp",  {31'h0, bus.mem_myexp},  {31'h0, !m_cur.myslot});
                end
            end
            m_len++;
            if (bus.mem_ready) begin
                bus.mem_ready = 1'b0;
            end else if (m_cnt == m_cur.wait_clks) begin
                m_old = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 32'h0;
                if (bus.mem_write == 4'b0000) begin
                    bus.mem_rdata = m_old;
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (bus.mem_write[b]) m_old[b*8 +: 8] = bus.mem_wdata[b*8 +: 8];
                    mem[bus.mem_addr] = m_old;
                end
                bus.mem_ready = 1'b1;
            end else begin
                m_cnt++;
            end
        end else begin
            if (m_busy && m_cur.vlen != 0)
                chk("mem_valid_len", m_len, m_cur.vlen);
            m_busy        = 1'b0;
            bus.mem_ready = 1'b0;
        end
    end

    // ---------------- ACK monitor (bus outputs change on rising edge) -----
    ack_exp_t a_cur;
    logic     ack_prev = 1'b0;

    always @(negedge clk) begin
        if (ack_prev) begin
            chk("ack_one_clock_ackn", {31'h0, bus.nub_ackn_o}, 32'h1);
            chk("ack_one_clock_oe", {30'h0, bus.nub_ctl_oe, bus.nub_adn_oe}, 32'h0);
        end
        ack_prev = 1'b0;
        if (bus.nub_ackn_o === 1'b0) begin
            ack_prev = 1'b1;
            if (ack_q.size() == 0) begin
                unexpected("unexpected_ack");
            end else begin
                a_cur = ack_q.pop_front();
                chk("ack_ctl_oe",  {31'h0, bus.nub_ctl_oe}, 32'h1);
                chk("ack_tmn",     {30'h0, bus.nub_tmn_o},  {30'h0, a_cur.tmn});
                chk("ack_adn_oe",  {31'h0, bus.nub_adn_oe}, {31'h0, a_cur.oe});
                if (a_cur.oe)
                    chk("ack_adn_o", bus.nub_adn_o, a_cur.adn_o);
                chk("ack_latency_cyc", cyc, a_cur.at_cyc);
            end
        end
    end

    // ---------------- stimulus ----------------
    // lat = falling edges from START sampling to ACK sampling (read: wait+2,
    // write: wait+3).
    task automatic txn(input logic [31:0] addr, input bit wr, input bit bytem,
                       input logic [31:0] wdata, input bit push_mem,
                       input logic [31:0] e_addr, input logic [3:0] e_strb,
                       input bit e_slot, input int wait_clks, input int vlen,
                       input bit push_ack, input logic [1:0] e_tmn,
                       input logic [31:0] e_adn_o, input int lat);
        mem_exp_t m;
        ack_exp_t a;
        @(posedge clk);
        #1;
        m.addr = e_addr; m.strobe = e_strb; m.wdata = wdata; m.myslot = e_slot;
        m.wait_clks = wait_clks; m.vlen = vlen;
        a.tmn = e_tmn; a.oe = !wr; a.adn_o = e_adn_o; a.at_cyc = cyc + lat;
        if (push_mem) mem_q.push_back(m);
        if (push_ack) ack_q.push_back(a);
        bus.nub_startn = 1'b0;
        bus.nub_adn    = ~addr;
        bus.nub_tm1n   = ~wr;
        bus.nub_tm0n   = ~bytem;
        @(posedge clk);
        #1;
        bus.nub_startn = 1'b1;
        bus.nub_tm1n   = 1'b1;
        bus.nub_tm0n   = 1'b1;
        bus.nub_adn    = wr ? ~wdata : 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        bus.nub_adn    = 32'hFFFF_FFFF;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((ack_q.size() != 0 || mem_q.size() != 0) && n < 60) begin
            @(posedge clk);
            n++;
        end
        chk("txn_completes", {31'h0, (ack_q.size() == 0 && mem_q.size() == 0)}, 32'h1);
        repeat (2) @(posedge clk);
    endtask

    logic quiet_bad;

    initial begin
        bus.nub_idn    = 4'hF;          // card ID 0
        bus.nub_startn = 1'b1;
        bus.nub_adn    = 32'hFFFF_FFFF;
        bus.nub_tm0n   = 1'b1;
        bus.nub_tm1n   = 1'b1;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = 32'h0;

        // Reset values
        repeat (3) @(posedge clk);
        #2;
        chk("rst_mem_valid",  {31'h0, bus.mem_valid},  32'h0);
        chk("rst_mem_write",  {28'h0, bus.mem_write},  32'h0);
        chk("rst_mem_addr",   bus.mem_addr,            32'h0);
        chk("rst_mem_wdata",  bus.mem_wdata,           32'h0);
        chk("rst_mem_myslot_exp", {30'h0, bus.mem_myslot, bus.mem_myexp}, 32'h0);
        chk("rst_ackn",       {31'h0, bus.nub_ackn_o}, 32'h1);
        chk("rst_tmn",        {30'h0, bus.nub_tmn_o},  32'h3);
        chk("rst_adn_o",      bus.nub_adn_o,           32'hFFFF_FFFF);
        chk("rst_oe",         {30'h0, bus.nub_ctl_oe, bus.nub_adn_oe}, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Word write: low bits 11 select word mode on word $F0000000.
        txn(32'hF000_0003, 1, 0, 32'h8765_4321, 1, 32'hF000_0000, 4'b1111, 1, 0, 0,
            1, 2'b11, 32'h0, 3);
        wait_done();
        // Read back with one wait state: ACK at START+3.
        txn(32'hF000_0000, 0, 0, 32'h0, 1, 32'hF000_0000, 4'b0000, 1, 1, 0,
            1, 2'b11, 32'h789A_BCDE, 3);
        wait_done();
        // Byte 2 of word $F0000014 (lane bits 10 -> $F0000016).
        txn(32'hF000_0016, 1, 1, 32'h8765_4321, 1, 32'hF000_0014, 4'b0100, 1, 0, 0,
            1, 2'b11, 32'h0, 3);
        wait_done();
        txn(32'hF000_0016, 0, 1, 32'h0, 1, 32'hF000_0014, 4'b0000, 1, 2, 0,
            1, 2'b11, 32'hFF9A_FFFF, 4);
        wait_done();
        // Half 1 write then word read of the same word.
        txn(32'hF000_0022, 1, 0, 32'hAABB_CCDD, 1, 32'hF000_0020, 4'b1100, 1, 0, 0,
            1, 2'b11, 32'h0, 3);
        wait_done();
        txn(32'hF000_0023, 0, 0, 32'h0, 1, 32'hF000_0020, 4'b0000, 1, 0, 0,
            1, 2'b11, 32'h5544_FFFF, 2);
        wait_done();
        // Super slot space of card 0.
        txn(32'h0123_4567, 1, 0, 32'h0C0F_FEE5, 1, 32'h0123_4564, 4'b1111, 0, 2, 0,
            1, 2'b11, 32'h0, 5);
        wait_done();
        txn(32'h0123_4567, 0, 0, 32'h0, 1, 32'h0123_4564, 4'b0000, 0, 0, 0,
            1, 2'b11, 32'hF3F0_011A, 2);
        wait_done();

        // Another card's slot space: nothing happens.
        txn(32'hF100_0000, 0, 0, 32'h0, 0, 32'h0, 4'b0000, 1, 0, 0,
            0, 2'b11, 32'h0, 0);
        quiet_bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.mem_valid !== 1'b0 || bus.nub_ackn_o !== 1'b1 ||
                bus.nub_ctl_oe !== 1'b0 || bus.nub_adn_oe !== 1'b0)
                quiet_bad = 1'b1;
        end
        chk("nohit_quiet", {31'h0, quiet_bad}, 32'h0);
        wait_done();

        // Never-ready target: 8-clock timeout, error status, all-ones data.
        // A second START during MEM must be ignored.
        txn(32'hF000_0040, 0, 0, 32'h0, 1, 32'hF000_0040, 4'b0000, 1, 1000, TOUT,
            1, 2'b10, 32'h0000_0000, TOUT + 1);
        @(posedge clk);
        #1;
        bus.nub_startn = 1'b0;
        bus.nub_adn    = ~32'hF000_0000;
        @(posedge clk);
        #1;
        bus.nub_startn = 1'b1;
        bus.nub_adn    = 32'hFFFF_FFFF;
        wait_done();

        // Reset pulse while in MEM: immediate quiet outputs, no ACK.
        txn(32'hF000_0050, 0, 0, 32'h0, 1, 32'hF000_0050, 4'b0000, 1, 1000, 0,
            0, 2'b11, 32'h0, 0);
        repeat (3) @(posedge clk);
        chk("pre_rst_mem_valid", {31'h0, bus.mem_valid}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_mem_valid", {31'h0, bus.mem_valid}, 32'h0);
        chk("midrst_oe", {30'h0, bus.nub_ctl_oe, bus.nub_adn_oe}, 32'h0);
        chk("midrst_ackn", {31'h0, bus.nub_ackn_o}, 32'h1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (TOUT + 4) @(posedge clk);
        // Next START is serviced normally.
        txn(32'hF000_0000, 0, 0, 32'h0, 1, 32'hF000_0000, 4'b0000, 1, 1, 0,
            1, 2'b11, 32'h789A_BCDE, 3);
        wait_done();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/nubus_slave_resp.md
Name: nubus_slave_resp

Overview:
- NuBus slave-side responder: watches the bus for START cycles addressed to this card.
- Decodes address and transfer mode, then runs one local memory transaction on the mem_* interface.
- Terminates the NuBus cycle with ACK, status and, for reads, read data.
- Counterpart to the CPU-side NuBus master: the master initiates the cycle, this block completes it. It feeds nubus_memory-style local targets.

Parameters:
- SLOT_ENABLE, 1, respond to standard slot space $Fsxx_xxxx (s = ~nub_idn).
- EXP_ENABLE, 1, respond to super slot space $sxxx_xxxx.
- TIMEOUT_CLOCKS, 255, clocks to wait for mem_ready before acking with error status; 8-bit counter.

Ports:
- nub_clkn  in  1  NuBus clock; falling edge samples, rising edge drives.
- nub_resetn  in  1  asynchronous active-low reset.
- nub_idn  in  4  slot ID, active low.
- nub_startn  in  1  START, active low.
- nub_adn  in  32  address/data bus as sampled, active low.
- nub_tm0n  in  1  transfer mode bit 0, active low.
- nub_tm1n  in  1  transfer mode bit 1, active low.
- nub_adn_o  out  32  read data to drive, active low.
- nub_adn_oe  out  1  enable for nub_adn_o.
- nub_tmn_o  out  2  {tm1n,tm0n} status to drive during ACK.
- nub_ackn_o  out  1  ACK output, active low.
- nub_ctl_oe  out  1  enable for tmn_o and ackn_o.
- mem_valid  out  1  local request.
- mem_write  out  4  byte strobes; 0 = read.
- mem_addr  out  32  true-polarity address.
- mem_wdata  out  32  true-polarity write data.
- mem_myslot  out  1  request targets slot space.
- mem_myexp  out  1  request targets super slot space.
- mem_ready  in  1  local target done.
- mem_rdata  in  32  local read data.

Behaviour:
- Clocking and reset
  - One clock: nub_clkn. nub_resetn is asynchronous active-low.
  - FSM, counters and mem_* registers update on the falling edge of nub_clkn. Bus output registers update on the rising edge.
  - Reset values: mem_valid=0, mem_write=0, mem_addr=0, mem_wdata=0, mem_myslot=0, mem_myexp=0, nub_ackn_o=1, nub_tmn_o=2'b11, nub_adn_o=all 1s, all oe=0, state=IDLE.
  - Reset asserted mid-cycle aborts immediately: all enables drop asynchronously and no ACK is issued.
- Address decode at START (falling edge with nub_startn=0)
  - addr = ~nub_adn.
  - Slot hit = SLOT_ENABLE and addr[31:24]=={4'hF,~nub_idn}.
  - Exp hit = EXP_ENABLE and addr[31:28]==~nub_idn and addr[31:28]!=4'hF.
  - No hit: stay IDLE and drive nothing.
- Mode decode: write = ~tm1n. The lane decode table below lives in the package.
  - tm0 asserted: byte access, lane = addr[1:0], strobe is one-hot.
  - tm0 negated, addr[1:0]=2'b00: half 0, strobe 0011.
  - tm0 negated, addr[1:0]=2'b10: half 1, strobe 1100.
  - tm0 negated, addr[1:0]=2'b11: word, strobe 1111.
  - tm0 negated, addr[1:0]=2'b01: word, strobe 1111 (reserved, treated as word).
  - mem_addr = {addr[31:2],2'b00}.
- FSM states: IDLE, WDATA, MEM, ACK.
  - IDLE: on a hit, latch address, mode and myslot/myexp. Write goes to WDATA; read goes to MEM with mem_valid=1.
  - WDATA: next falling edge latches mem_wdata=~nub_adn, sets mem_write=strobe and mem_valid=1, then goes to MEM.
  - MEM: mem_ready is sampled each falling edge.
    - On mem_ready=1: latch mem_rdata, set status=complete (2'b11), clear mem_valid and mem_write, go to ACK. A zero-wait ready on the first MEM edge is legal.
    - Counter reaches TIMEOUT_CLOCKS: clear mem_valid, set status=error (tm1n=1, tm0n=0), go to ACK.
  - ACK: the following rising edge drives nub_ackn_o=0, nub_tmn_o=status and nub_ctl_oe=1.
    - Reads also drive nub_adn_o=~rdata and nub_adn_oe=1 (read data is all 1s on error).
    - Held exactly one clock; the next rising edge releases all enables and restores idle levels. The FSM returns to IDLE on the falling edge after ACK is driven.
- Timing: read latency from START to ACK is mem wait + 2 clocks. Write adds one clock for WDATA.
- START seen while not IDLE is ignored; no pipelining.

Decomposition:
- Package nubus_pkg holds:
  - tm status constants: TM_COMPLETE, TM_ERROR, TM_TIMEOUT, TM_TRYAGAIN.
  - wstrb constants: WRITE_WR_WORD, WRITE_WR_HALF_0/1, WRITE_WR_BYTE_0..3.
  - state enum.
  - decode function mode_to_wstrb(tm0n, adn[1:0]).
- One sub-module nubus_slave_decode: combinational slot/exp hit and strobe decode, kept separate for unit test.

Test Plan:
- Card ID 0, START addr $F0000000, write word $87654321 → mem_addr=$F0000000, mem_write=1111, mem_wdata=$87654321; ACK one clock with tmn=11.
- Read $F0000000 after the word write, memory wait 1 → nub_adn_o=~$87654321 with adn_oe during ACK; ACK at START+3 clocks.
- Write byte 2 at $F0000014 with data $87654321 → mem_write=0100; a read-back returns $00650000 from zeroed memory.
- START at $F1000000 with card ID 0 → mem_valid never asserts, ackn_o stays 1, all oe=0.
- Target never ready, TIMEOUT_CLOCKS=8 → mem_valid drops after 8 clocks; ACK with tmn=10; a read returns all-ones data.
- nub_resetn pulsed low during MEM → mem_valid=0 and all oe=0 immediately; no ACK; the next START is serviced normally.
